booth_mult_param: RTL and testbench

//   Parametrised multi-cycle radix-4 Booth multiplier; next generation of the 32-bit ALU-side multiplier.

---
 rtl/mult_pkg.sv | 56 +++++
 rtl/booth_r4_recode.sv | 41 ++++
 rtl/booth_mult_param.sv | 149 ++++++++++++++
 tb/tb_booth_mult_param.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the radix-4 Booth multiplier family:
//   - mult_state_t  : control FSM states (IDLE / RUN / DONE)
//   - booth_digit_t : recoded radix-4 Booth digit {0, +1, +2, -1, -2}
//   - booth_sel_t   : partial-product select lines {neg, one, two}
//   - digit_to_sel  : maps a Booth digit onto its select lines
//   - n_iter        : number of radix-4 iterations for a given operand width
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mult_state_t;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_digit_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

  localparam booth_sel_t SEL_ZERO = booth_sel_t'(3'b000);
  localparam booth_sel_t SEL_POS1 = booth_sel_t'(3'b010);
  localparam booth_sel_t SEL_POS2 = booth_sel_t'(3'b001);
  localparam booth_sel_t SEL_NEG1 = booth_sel_t'(3'b110);
  localparam booth_sel_t SEL_NEG2 = booth_sel_t'(3'b101);

  function automatic booth_sel_t digit_to_sel(booth_digit_t d);
    booth_sel_t s;
    case (d)
      BD_POS1: s = SEL_POS1;
      BD_POS2: s = SEL_POS2;
      BD_NEG1: s = SEL_NEG1;
      BD_NEG2: s = SEL_NEG2;
      default: s = SEL_ZERO;
    endcase
    return s;
  endfunction

  // The multiplier is extended by two bits (sign/zero) so that the same
  // signed Booth recoding serves both modes; that gives width/2+1 digits.
  function automatic int n_iter(int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// ---------------------------------------------------------------------------
// booth_r4_recode
// Combinational radix-4 Booth recoder. Turns a 3-bit overlapping window
// {b[i+1], b[i], b[i-1]} of the multiplier into partial-product selects.
// Ports:
//   window_i [2:0]  multiplier window, bit 0 is the guard/previous bit
//   neg_o           subtract the selected multiple
//   one_o           select 1x multiplicand
//   two_o           select 2x multiplicand
// ---------------------------------------------------------------------------
module booth_r4_recode
  import mult_pkg::*;
(
  input  logic [2:0] window_i,
  output logic       neg_o,
  output logic       one_o,
  output logic       two_o
);

  booth_digit_t digit;
  booth_sel_t   sel;

  // Standard radix-4 Booth table: digit = -2*b[i+1] + b[i] + b[i-1].
  // Window 111 is a zero digit with neg clear, so no -0 reaches the adder.
  always_comb begin
    digit = BD_ZERO;
    case (window_i)
      3'b001, 3'b010: digit = BD_POS1;
      3'b011:         digit = BD_POS2;
      3'b100:         digit = BD_NEG2;
      3'b101, 3'b110: digit = BD_NEG1;
      default:        digit = BD_ZERO;
    endcase
  end

  assign sel   = digit_to_sel(digit);
  assign neg_o = sel.neg;
  assign one_o = sel.one;
  assign two_o = sel.two;

endmodule

// File: rtl/booth_mult_param.sv
// ---------------------------------------------------------------------------
// booth_mult_param
// Multi-cycle radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned. One Booth digit is retired per clock; a result appears
// WIDTH/2+1 edges after the start edge and is held until the next start.
// WIDTH must be even and at least 4.
// Ports:
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset
//   ctrl_MULT        start / restart pulse, samples operands and mode
//   ctrl_signed      1 = two's complement operands, 0 = unsigned
//   data_operandA    multiplicand
//   data_operandB    multiplier
//   data_result      low half of product (0 unless data_resultRDY)
//   data_result_hi   high half of product (0 unless data_resultRDY)
//   data_exception   product does not fit in WIDTH bits for the mode
//   data_resultRDY   result valid
//   data_busy        iteration in progress
// ---------------------------------------------------------------------------
module booth_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam int N_ITER = n_iter(WIDTH);
  // Operands carry two extension bits so unsigned values stay positive
  // under signed Booth arithmetic and the digit count is whole.
  localparam int XW     = WIDTH + 2;
  // Accumulator headroom: |2*A| with A of XW bits needs XW+2 signed bits.
  localparam int AW     = WIDTH + 4;
  localparam int CW     = $clog2(N_ITER + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(N_ITER - 1);

  mult_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [XW-1:0] mul_q, mul_d;
  logic          guard_q, guard_d;
  logic [XW-1:0] mcand_q, mcand_d;
  logic          signedMode_q, signedMode_d;

  logic             boothNeg, boothOne, boothTwo;
  logic [AW-1:0]    mcandWide, addend, sum;
  logic [WIDTH-1:0] prodLo, prodHi;
  logic             overflow;

  booth_r4_recode u_recode (
    .window_i ({mul_q[1:0], guard_q}),
    .neg_o    (boothNeg),
    .one_o    (boothOne),
    .two_o    (boothTwo)
  );

  // Partial-product adder: acc + d*A, with d taken from the recoder.
  always_comb begin
    mcandWide = {{2{mcand_q[XW-1]}}, mcand_q};
    addend    = '0;
    if (boothOne) begin
      addend = mcandWide;
    end else if (boothTwo) begin
      addend = mcandWide << 1;
    end
    sum = boothNeg ? (acc_q - addend) : (acc_q + addend);
  end

  // Next-state logic. A start pulse wins in every state, which gives the
  // restart behaviour for free: a partial result is simply overwritten.
  // In RUN the register {acc, mul, guard} is shifted arithmetically right
  // by two after the add, so the next window lands in the low three bits.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    acc_d        = acc_q;
    mul_d        = mul_q;
    guard_d      = guard_q;
    mcand_d      = mcand_q;
    signedMode_d = signedMode_q;

    if (ctrl_MULT) begin
      state_d      = ST_RUN;
      count_d      = '0;
      acc_d        = '0;
      mul_d        = {{2{ctrl_signed & data_operandB[WIDTH-1]}}, data_operandB};
      guard_d      = 1'b0;
      mcand_d      = {{2{ctrl_signed & data_operandA[WIDTH-1]}}, data_operandA};
      signedMode_d = ctrl_signed;
    end else if (state_q == ST_RUN) begin
      acc_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
      mul_d   = {sum[1:0], mul_q[XW-1:2]};
      guard_d = mul_q[1];
      count_d = count_q + 1'b1;
      if (count_q == LAST_COUNT) begin
        state_d = ST_DONE;
      end
    end
  end

  // State and datapath registers, cleared asynchronously so outputs drop
  // to zero as soon as reset_n falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      acc_q        <= '0;
      mul_q        <= '0;
      guard_q      <= 1'b0;
      mcand_q      <= '0;
      signedMode_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      mul_q        <= mul_d;
      guard_q      <= guard_d;
      mcand_q      <= mcand_d;
      signedMode_q <= signedMode_d;
    end
  end

  // After the last shift the low XW product bits sit in mul and the rest in
  // acc; the 2*WIDTH product straddles the boundary.
  assign prodLo = mul_q[WIDTH-1:0];
  assign prodHi = {acc_q[WIDTH-3:0], mul_q[XW-1:WIDTH]};

  // Overflow test on the final product; MIN * -1 falls out naturally since
  // its high half is zero while the low half's sign bit is set.
  assign overflow = signedMode_q ? (prodHi != {WIDTH{prodLo[WIDTH-1]}})
                                 : (prodHi != '0);

  assign data_resultRDY = (state_q == ST_DONE);
  assign data_busy      = (state_q == ST_RUN);
  assign data_result    = data_resultRDY ? prodLo : '0;
  assign data_result_hi = data_resultRDY ? prodHi : '0;
  assign data_exception = data_resultRDY & overflow;

endmodule

// File: tb/tb_booth_mult_param.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_param
// Drives a 32-bit and an 8-bit booth_mult_param. A behavioural model tracks
// the expected busy/ready timing and the full product computed with plain
// integer arithmetic; a compare process checks both instances each cycle.
// ---------------------------------------------------------------------------
module tb_booth_mult_param;

  localparam int N32 = 17;
  localparam int N8  = 5;

  logic clock;
  logic reset_n;

  logic        mult32, sgn32;
  logic [31:0] a32, b32, lo32, hi32;
  logic        exc32, rdy32, busy32;

  logic        mult8, sgn8;
  logic [7:0]  a8, b8, lo8, hi8;
  logic        exc8, rdy8, busy8;

  int checks = 0;
  int errors = 0;
  int cyc, first, pulses;
  logic prev;

  booth_mult_param #(.WIDTH(32)) dut32 (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (mult32),
    .ctrl_signed    (sgn32),
    .data_operandA  (a32),
    .data_operandB  (b32),
    .data_result    (lo32),
    .data_result_hi (hi32),
    .data_exception (exc32),
    .data_resultRDY (rdy32),
    .data_busy      (busy32)
  );

  booth_mult_param #(.WIDTH(8)) dut8 (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (mult8),
    .ctrl_signed    (sgn8),
    .data_operandA  (a8),
    .data_operandB  (b8),
    .data_result    (lo8),
    .data_result_hi (hi8),
    .data_exception (exc8),
    .data_resultRDY (rdy8),
    .data_busy      (busy8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Exact product via integer arithmetic; returns {exception, product}.
  function automatic logic [64:0] mulModel(input int w, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, lim;
    logic [63:0] mask, prod;
    logic exc;
    sa = longint'({32'b0, a});
    sb = longint'({32'b0, b});
    if (sgn && a[w-1]) sa = sa - (64'sd1 << w);
    if (sgn && b[w-1]) sb = sb - (64'sd1 << w);
    p    = sa * sb;
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    prod = 64'(p) & mask;
    lim  = 64'sd1 << (w - 1);
    if (sgn) exc = (p < -lim) || (p >= lim);
    else     exc = (prod >> w) != 64'd0;
    return {exc, prod};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Behavioural model of the 32-bit instance: latency counter plus product.
  logic        m32Busy = 1'b0, m32Rdy = 1'b0, m32Exc = 1'b0;
  int          m32Left = 0;
  logic [64:0] m32Pend = '0;
  logic [63:0] m32Prod = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m32Busy <= 1'b0; m32Rdy <= 1'b0; m32Left <= 0; m32Prod <= '0; m32Exc <= 1'b0;
    end else if (mult32) begin
      m32Pend <= mulModel(32, sgn32, a32, b32);
      m32Busy <= 1'b1; m32Rdy <= 1'b0; m32Left <= N32;
    end else if (m32Busy) begin
      m32Left <= m32Left - 1;
      if (m32Left == 1) begin
        m32Busy <= 1'b0; m32Rdy <= 1'b1;
        m32Prod <= m32Pend[63:0]; m32Exc <= m32Pend[64];
      end
    end
  end

  // Behavioural model of the 8-bit instance.
  logic        m8Busy = 1'b0, m8Rdy = 1'b0, m8Exc = 1'b0;
  int          m8Left = 0;
  logic [64:0] m8Pend = '0;
  logic [63:0] m8Prod = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m8Busy <= 1'b0; m8Rdy <= 1'b0; m8Left <= 0; m8Prod <= '0; m8Exc <= 1'b0;
    end else if (mult8) begin
      m8Pend <= mulModel(8, sgn8, {24'b0, a8}, {24'b0, b8});
      m8Busy <= 1'b1; m8Rdy <= 1'b0; m8Left <= N8;
    end else if (m8Busy) begin
      m8Left <= m8Left - 1;
      if (m8Left == 1) begin
        m8Busy <= 1'b0; m8Rdy <= 1'b1;
        m8Prod <= m8Pend[63:0]; m8Exc <= m8Pend[64];
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    checkOutput("c32_busy", 64'(busy32), 64'(m32Busy));
    checkOutput("c32_rdy",  64'(rdy32),  64'(m32Rdy));
    checkOutput("c32_lo",   64'(lo32),   m32Rdy ? 64'(m32Prod[31:0])  : 64'd0);
    checkOutput("c32_hi",   64'(hi32),   m32Rdy ? 64'(m32Prod[63:32]) : 64'd0);
    checkOutput("c32_exc",  64'(exc32),  64'(m32Rdy & m32Exc));
    checkOutput("c8_busy",  64'(busy8),  64'(m8Busy));
    checkOutput("c8_rdy",   64'(rdy8),   64'(m8Rdy));
    checkOutput("c8_lo",    64'(lo8),    m8Rdy ? 64'(m8Prod[7:0])  : 64'd0);
    checkOutput("c8_hi",    64'(hi8),    m8Rdy ? 64'(m8Prod[15:8]) : 64'd0);
    checkOutput("c8_exc",   64'(exc8),   64'(m8Rdy & m8Exc));
    checkOutput("c8_excl",  64'(busy8 & rdy8), 64'd0);
  end

  // Called at a falling edge; the start is sampled on the next rising edge
  // and the task returns at the falling edge right after it.
  task automatic applyStimulus32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    mult32 = 1'b1; sgn32 = sgn; a32 = a; b32 = b;
    @(negedge clock);
    mult32 = 1'b0;
  endtask

  task automatic applyStimulus8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    mult8 = 1'b1; sgn8 = sgn; a8 = a; b8 = b;
    @(negedge clock);
    mult8 = 1'b0;
  endtask

  // Counts falling edges until ready; operand/mode inputs are scrambled
  // meanwhile to show they are not sampled after the start edge.
  task automatic waitRdy32(output int n);
    n = 0;
    while (rdy32 !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
      sgn32 = 1'($urandom_range(0, 1)); a32 = $urandom; b32 = $urandom;
    end
    if (rdy32 !== 1'b1) checkOutput("t32_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitRdy8(output int n);
    n = 0;
    while (rdy8 !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
      sgn8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
    end
    if (rdy8 !== 1'b1) checkOutput("t8_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    mult32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    mult8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_busy", 64'(busy32), 64'd0);
    checkOutput("rst_rdy",  64'(rdy32),  64'd0);
    checkOutput("rst_lo",   64'(lo32),   64'd0);
    checkOutput("rst_hi",   64'(hi32),   64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 7 * -3 = -21
    applyStimulus32(1'b1, 32'd7, 32'hFFFF_FFFD);
    waitRdy32(cyc);
    checkOutput("t1_lat", 64'(cyc), 64'd17);
    checkOutput("t1_lo",  64'(lo32), 64'hFFFF_FFEB);
    checkOutput("t1_hi",  64'(hi32), 64'hFFFF_FFFF);
    checkOutput("t1_exc", 64'(exc32), 64'd0);

    // MIN * -1 = +2^31 overflows signed 32 bits
    applyStimulus32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitRdy32(cyc);
    checkOutput("t2_lo",  64'(lo32), 64'h8000_0000);
    checkOutput("t2_hi",  64'(hi32), 64'h0);
    checkOutput("t2_exc", 64'(exc32), 64'd1);

    // (2^32-1)^2 unsigned, then (-1)*(-1) = 1 signed with a zero high half
    applyStimulus32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitRdy32(cyc);
    checkOutput("t3u_lo",  64'(lo32), 64'h1);
    checkOutput("t3u_hi",  64'(hi32), 64'hFFFF_FFFE);
    checkOutput("t3u_exc", 64'(exc32), 64'd1);
    applyStimulus32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitRdy32(cyc);
    checkOutput("t3s_lo",  64'(lo32), 64'h1);
    checkOutput("t3s_hi",  64'(hi32), 64'h0);
    checkOutput("t3s_exc", 64'(exc32), 64'd0);

    // Restart eight edges into a run: only the second job completes
    applyStimulus32(1'b1, 32'd5, 32'd6);
    repeat (7) @(negedge clock);
    applyStimulus32(1'b1, 32'd3, 32'd4);
    first = 0; pulses = 0; prev = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (rdy32 && !prev) begin
        pulses++;
        if (first == 0) first = k;
      end
      prev = rdy32;
    end
    checkOutput("t4_lat",    64'(first),  64'd17);
    checkOutput("t4_pulses", 64'(pulses), 64'd1);
    checkOutput("t4_lo",     64'(lo32),   64'd12);

    // Reset in mid-run clears outputs without waiting for a clock edge
    applyStimulus32(1'b0, 32'd9, 32'd9);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t5_busy", 64'(busy32), 64'd0);
    checkOutput("t5_rdy",  64'(rdy32),  64'd0);
    checkOutput("t5_lo",   64'(lo32),   64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    checkOutput("t5_norun", 64'(rdy32 | busy32), 64'd0);

    // A few random 32-bit products
    for (int i = 0; i < 6; i++) begin
      applyStimulus32(1'($urandom_range(0, 1)), $urandom, $urandom);
      waitRdy32(cyc);
      checkOutput("r32_lat", 64'(cyc), 64'd17);
    end

    // 8-bit corner cases, then a random sweep, started back-to-back
    applyStimulus8(1'b1, 8'h80, 8'hFF);
    waitRdy8(cyc);
    checkOutput("e8_lo",  64'(lo8), 64'h80);
    checkOutput("e8_hi",  64'(hi8), 64'h00);
    checkOutput("e8_exc", 64'(exc8), 64'd1);
    applyStimulus8(1'b1, 8'h80, 8'h80);
    waitRdy8(cyc);
    checkOutput("e8b_hi", 64'(hi8), 64'h40);
    applyStimulus8(1'b0, 8'hFF, 8'hFF);
    waitRdy8(cyc);
    checkOutput("e8c_lo", 64'(lo8), 64'h01);
    checkOutput("e8c_hi", 64'(hi8), 64'hFE);
    for (int i = 0; i < 60; i++) begin
      applyStimulus8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      waitRdy8(cyc);
      checkOutput("r8_lat", 64'(cyc), 64'd5);
    end

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
